fir_mac_serial: RTL

//  Downstream stage of the 21-tap symmetric delay chain. The chain pre-adds the 10 mirrored tap pairs plus the centre tap.
//  Per 600 kHz sample, this block walks the 11 pre-added values through one shared multiplier: iTapSum[k] * coeff[k].
//  It accumulates the 11 products, then rounds, scales and saturates the result to oFirOut with a 1-cycle oFirValid.
//  The 12 MHz / 600 kHz ratio gives 20 clocks per sample. One frame uses 15 of them.

---
 rtl/fir_mac_serial_pkg.sv | 26 ++
 rtl/fir_coeff_regfile.sv | 42 ++++
 rtl/fir_mac_serial.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_serial_pkg.sv
// Shared constants, FSM state encoding and coefficient-write payload for the serial FIR MAC.
package fir_mac_serial_pkg;

    localparam int unsigned FIR_IN_W      = 4;
    localparam int unsigned FIR_COEF_W    = 10;
    localparam int unsigned FIR_NUM_TAPS  = 11;
    localparam int unsigned FIR_ACC_W     = 18;
    localparam int unsigned FIR_SHIFT     = 7;
    localparam int unsigned FIR_OUT_W     = 8;
    localparam int unsigned TAP_SEL_W     = 4;
    localparam int unsigned TAP_CENTRE    = 10;
    localparam int unsigned SAMPLE_PERIOD = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_t;

    typedef struct packed {
        logic [TAP_SEL_W-1:0]  addr;
        logic [FIR_COEF_W-1:0] data;
    } coeff_wr_t;

endpackage

// File: rtl/fir_coeff_regfile.sv
// Coefficient bank: NUM_TAPS signed registers, one synchronous write port, one combinational read port.
module fir_coeff_regfile #(
    parameter int unsigned COEF_W   = 10,
    parameter int unsigned NUM_TAPS = 11,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic signed [COEF_W-1:0] o_rdata_c
);

    logic signed [COEF_W-1:0] r_coef [NUM_TAPS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (i_waddr == ADDR_W'(i)) begin
                    r_coef[i] <= i_wdata;
                end
            end
        end
    end

    // Out-of-range read addresses return zero.
    always_comb begin
        o_rdata_c = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (i_raddr == ADDR_W'(i)) begin
                o_rdata_c = r_coef[i];
            end
        end
    end

endmodule

// File: rtl/fir_mac_serial.sv
// Serial MAC for the 21-tap symmetric FIR: walks 11 pre-added taps through one multiplier per
// sample frame, then rounds, scales and saturates the sum to a registered output.
module fir_mac_serial
    import fir_mac_serial_pkg::*;
(
    input  logic                         iClk12M,
    input  logic                         iRsn,
    input  logic                         iEnSample600k,
    output logic [TAP_SEL_W-1:0]         oTapSel,
    input  logic signed [FIR_IN_W-1:0]   iTapSum,
    input  logic                         iCoeffWe,
    input  logic [TAP_SEL_W-1:0]         iCoeffAddr,
    input  logic signed [FIR_COEF_W-1:0] iCoeffData,
    output logic                         oCoeffErr,
    output logic signed [FIR_OUT_W-1:0]  oFirOut,
    output logic                         oFirValid,
    output logic                         oOverrun,
    output logic                         oBusy
);

    localparam logic [TAP_SEL_W-1:0]        L_TAP_LAST = TAP_SEL_W'(TAP_CENTRE);
    localparam logic signed [FIR_ACC_W-1:0] L_RND      = FIR_ACC_W'(1 << (FIR_SHIFT - 1));
    localparam logic signed [FIR_ACC_W-1:0] L_OUT_MAX  = FIR_ACC_W'((1 << (FIR_OUT_W - 1)) - 1);
    localparam logic signed [FIR_ACC_W-1:0] L_OUT_MIN  = FIR_ACC_W'(-(1 << (FIR_OUT_W - 1)));

    fir_state_t                   r_state;
    fir_state_t                   w_state_nxt;
    logic [TAP_SEL_W-1:0]         r_tap_sel;
    logic [TAP_SEL_W-1:0]         w_tap_sel_nxt;
    logic                         r_drain_last;
    logic                         w_drain_last_nxt;
    logic                         w_clr_acc;
    logic                         w_do_out;

    logic [TAP_SEL_W-1:0]         r_sel_d;
    logic                         r_mul_en;
    logic                         r_acc_en;
    logic signed [FIR_ACC_W-1:0]  r_prod;
    logic signed [FIR_ACC_W-1:0]  r_acc;
    logic signed [FIR_OUT_W-1:0]  r_fir_out;
    logic                         r_fir_valid;
    logic                         r_overrun;
    logic                         r_coeff_err;
    logic                         r_busy;
    coeff_wr_t                    r_pend;
    logic                         r_pend_vld;

    logic                         w_idle;
    logic                         w_wr_ok;
    logic                         w_pend_commit;
    logic                         w_rf_we;
    logic [TAP_SEL_W-1:0]         w_rf_addr;
    logic signed [FIR_COEF_W-1:0] w_rf_data;
    logic signed [FIR_COEF_W-1:0] w_coef_c;
    logic signed [FIR_ACC_W-1:0]  w_tap_ext;
    logic signed [FIR_ACC_W-1:0]  w_coef_ext;
    logic signed [FIR_ACC_W-1:0]  w_prod;
    logic signed [FIR_ACC_W-1:0]  w_sum;
    logic signed [FIR_ACC_W-1:0]  w_shr;
    logic signed [FIR_OUT_W-1:0]  w_sat;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_wr_ok = iCoeffWe && w_idle && (iCoeffAddr <= L_TAP_LAST);

    // A write that coincides with a frame start is parked until the frame ends, so that frame sees the old value.
    assign w_pend_commit = (r_state == ST_OUT) && r_pend_vld;
    assign w_rf_we       = (w_wr_ok && !iEnSample600k) || w_pend_commit;
    assign w_rf_addr     = w_pend_commit ? r_pend.addr : iCoeffAddr;
    assign w_rf_data     = w_pend_commit ? $signed(r_pend.data) : iCoeffData;

    fir_coeff_regfile #(
        .COEF_W   (FIR_COEF_W),
        .NUM_TAPS (FIR_NUM_TAPS),
        .ADDR_W   (TAP_SEL_W)
    ) u_coeff_regfile (
        .i_clk     (iClk12M),
        .i_rst_n   (iRsn),
        .i_we      (w_rf_we),
        .i_waddr   (w_rf_addr),
        .i_wdata   (w_rf_data),
        .i_raddr   (r_sel_d),
        .o_rdata_c (w_coef_c)
    );

    assign w_tap_ext  = FIR_ACC_W'(iTapSum);
    assign w_coef_ext = FIR_ACC_W'(w_coef_c);
    assign w_prod     = w_tap_ext * w_coef_ext;

    // Final sum includes the last product, which lands on the same edge the output is registered.
    assign w_sum = r_acc + r_prod;
    assign w_shr = (w_sum + L_RND) >>> FIR_SHIFT;

    always_comb begin
        w_sat = FIR_OUT_W'(w_shr);
        if (w_shr > L_OUT_MAX) begin
            w_sat = FIR_OUT_W'(L_OUT_MAX);
        end else if (w_shr < L_OUT_MIN) begin
            w_sat = FIR_OUT_W'(L_OUT_MIN);
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tap_sel_nxt    = '0;
        w_drain_last_nxt = 1'b0;
        w_clr_acc        = 1'b0;
        w_do_out         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (iEnSample600k) begin
                    w_state_nxt = ST_FETCH;
                    w_clr_acc   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (r_tap_sel == L_TAP_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_tap_sel_nxt = r_tap_sel + TAP_SEL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_drain_last) begin
                    w_state_nxt = ST_OUT;
                    w_do_out    = 1'b1;
                end else begin
                    w_drain_last_nxt = 1'b1;
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_tap_sel    <= '0;
            r_drain_last <= 1'b0;
            r_sel_d      <= '0;
            r_mul_en     <= 1'b0;
            r_acc_en     <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_fir_out    <= '0;
            r_fir_valid  <= 1'b0;
            r_overrun    <= 1'b0;
            r_coeff_err  <= 1'b0;
            r_busy       <= 1'b0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
        end else begin
            r_tap_sel    <= w_tap_sel_nxt;
            r_drain_last <= w_drain_last_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_overrun    <= iEnSample600k && !w_idle;
            r_coeff_err  <= iCoeffWe && !w_wr_ok;
            r_fir_valid  <= w_do_out;
            // Tap select at t, product at t+1 edge, accumulate at t+2 edge.
            r_sel_d      <= r_tap_sel;
            r_mul_en     <= (r_state == ST_FETCH);
            r_acc_en     <= r_mul_en;
            if (r_mul_en) begin
                r_prod <= w_prod;
            end
            if (w_clr_acc) begin
                r_acc <= '0;
            end else if (r_acc_en) begin
                r_acc <= w_sum;
            end
            if (w_do_out) begin
                r_fir_out <= w_sat;
            end
            if (w_wr_ok && iEnSample600k) begin
                r_pend_vld <= 1'b1;
                r_pend     <= '{addr: iCoeffAddr, data: iCoeffData};
            end else if (w_pend_commit) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign oTapSel   = r_tap_sel;
    assign oCoeffErr = r_coeff_err;
    assign oFirOut   = r_fir_out;
    assign oFirValid = r_fir_valid;
    assign oOverrun  = r_overrun;
    assign oBusy     = r_busy;

endmodule
